hall_input_conditioner: RTL and testbench



---
 rtl/bldc_pkg.sv | 38 +++
 rtl/hall_glitch_filter.sv | 45 ++++
 rtl/hall_input_conditioner.sv | 124 ++++++++++++
 tb/tb_hall_input_conditioner.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/bldc_pkg.sv
// Shared BLDC hall-sensor definitions: the commutation sequence table,
// the code-to-index lookup and the decode event type.
package bldc_pkg;

  localparam logic [2:0] HALL_ILLEGAL_LO = 3'b000;
  localparam logic [2:0] HALL_ILLEGAL_HI = 3'b111;
  localparam logic [2:0] IDX_INVALID     = 3'd7;

  // Forward commutation order, index 0..5.
  localparam logic [2:0] HALL_SEQ [6] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b100, 3'b101};

  typedef enum logic [2:0] {
    EV_NONE,
    EV_FWD,
    EV_REV,
    EV_SKIP,
    EV_ILLEGAL,
    EV_RESYNC
  } hall_event_e;

  function automatic logic [2:0] hall_code_to_idx(input logic [2:0] code);
    logic [2:0] idx;
    idx = IDX_INVALID;
    for (int i = 0; i < 6; i++) begin
      if (HALL_SEQ[i] == code) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [2:0] idx_next(input logic [2:0] idx);
    return (idx == 3'd5) ? 3'd0 : idx + 3'd1;
  endfunction

  function automatic logic [2:0] idx_prev(input logic [2:0] idx);
    return (idx == 3'd0) ? 3'd5 : idx - 3'd1;
  endfunction

endpackage

// File: rtl/hall_glitch_filter.sv
// Two-flop synchroniser plus stability filter for the three hall lines.
// accept_o is combinational so the decoder can update on the same edge as hall_o.
module hall_glitch_filter #(
  parameter int unsigned FILTER_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] hall_i,
  output logic [2:0] hall_o,
  output logic [2:0] cand_o,
  output logic       accept_o
);

  localparam logic [7:0] CNT_MAX = 8'(FILTER_CYCLES - 1);

  logic [2:0] sync1_q, sync2_q, cand_q, hall_q;
  logic [7:0] cnt_q;

  assign accept_o = (cnt_q == CNT_MAX) && (cand_q != hall_q);
  assign hall_o   = hall_q;
  assign cand_o   = cand_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 3'b111;
      sync2_q <= 3'b111;
      cand_q  <= 3'b111;
      cnt_q   <= 8'd0;
      hall_q  <= 3'b111;
    end else begin
      // NOTE: all state here is updated with non-blocking assignments so each
      // flop samples the pre-edge value of its neighbour, as real flops do.
      sync1_q <= hall_i;
      sync2_q <= sync1_q;
      if (sync2_q != cand_q) begin
        cand_q <= sync2_q;
        cnt_q  <= 8'd0;
      end else if (cnt_q < CNT_MAX) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (accept_o) hall_q <= cand_q;
    end
  end

endmodule

// File: rtl/hall_input_conditioner.sv
// Hall input conditioner: filter, 6-step decode, step count, error count and
// commutation period. Period logic is built only with HALL_PERIOD_MEASURE_EN defined.
module hall_input_conditioner
  import bldc_pkg::*;
#(
  parameter int FILTER_CYCLES = 16,
  parameter int COUNT_WIDTH   = 16,
  parameter int PERIOD_WIDTH  = 20,
  parameter int ERR_WIDTH     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              hall,
  output logic [2:0]              hall_out,
  output logic                    step,
  output logic                    dir,
  output logic [COUNT_WIDTH-1:0]  count,
  output logic                    seq_err,
  output logic [ERR_WIDTH-1:0]    err_count,
  output logic [PERIOD_WIDTH-1:0] period,
  output logic                    period_valid,
  output logic                    stalled
);

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);
  localparam logic [ERR_WIDTH-1:0]   ERR_ONE = ERR_WIDTH'(1);

  logic [2:0]       cand, new_idx, prev_idx_q;
  logic             accept, is_step, fwd;
  hall_event_e      ev;

  logic             step_q, dir_q, seq_err_q;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [ERR_WIDTH-1:0]   err_q;

  hall_glitch_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter (
    .clk      (clk),
    .rst      (rst),
    .hall_i   (hall),
    .hall_o   (hall_out),
    .cand_o   (cand),
    .accept_o (accept)
  );

  always_comb begin
    // NOTE: defaults first, so every path assigns every output and no latch is inferred.
    new_idx = hall_code_to_idx(cand);
    ev      = EV_NONE;
    if (accept) begin
      if (new_idx == IDX_INVALID)                ev = EV_ILLEGAL;
      else if (prev_idx_q == IDX_INVALID)        ev = EV_RESYNC;
      else if (new_idx == idx_next(prev_idx_q))  ev = EV_FWD;
      else if (new_idx == idx_prev(prev_idx_q))  ev = EV_REV;
      else                                       ev = EV_SKIP;
    end
  end

  assign is_step = (ev == EV_FWD) || (ev == EV_REV);
  assign fwd     = (ev == EV_FWD);
  assign count_d = fwd ? count_q + CNT_ONE : count_q - CNT_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_idx_q <= IDX_INVALID;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      seq_err_q  <= 1'b0;
      count_q    <= '0;
      err_q      <= '0;
    end else begin
      step_q    <= is_step;
      seq_err_q <= (ev == EV_SKIP) || (ev == EV_ILLEGAL);
      // An illegal code maps to IDX_INVALID, which marks the history untrusted.
      if (accept) prev_idx_q <= new_idx;
      if (is_step) begin
        dir_q   <= fwd;
        count_q <= count_d;
      end
      if (seq_err_q && (err_q != '1)) err_q <= err_q + ERR_ONE;
    end
  end

  assign step      = step_q;
  assign dir       = dir_q;
  assign seq_err   = seq_err_q;
  assign count     = count_q;
  assign err_count = err_q;

`ifdef HALL_PERIOD_MEASURE_EN
  logic [PERIOD_WIDTH-1:0] pcnt_q, period_q;
  logic                    period_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q         <= '1;
      period_q       <= '1;
      period_valid_q <= 1'b0;
    end else begin
      period_valid_q <= 1'b0;
      if (is_step) begin
        pcnt_q <= PERIOD_WIDTH'(1);
        // Only a same-direction step after an unsaturated interval is a real period.
        if ((fwd == dir_q) && !stalled) begin
          period_q       <= pcnt_q;
          period_valid_q <= 1'b1;
        end else begin
          period_q <= '1;
        end
      end else if (pcnt_q != '1) begin
        pcnt_q <= pcnt_q + PERIOD_WIDTH'(1);
      end
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign stalled      = &pcnt_q;
`else
  assign period       = '1;
  assign period_valid = 1'b0;
  assign stalled      = 1'b0;
`endif

endmodule

// File: tb/tb_hall_input_conditioner.sv
// Scoreboard bench for hall_input_conditioner: each accepted hall code is
// predicted when driven and compared when hall_out changes.
module tb_hall_input_conditioner;

  localparam int F    = 16;
  localparam int CW   = 16;
  localparam int PW   = 10;
  localparam int EW   = 8;
  localparam int MAXP = (1 << PW) - 1;
`ifdef HALL_PERIOD_MEASURE_EN
  localparam bit PM = 1'b1;
`else
  localparam bit PM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    hall;
  logic [2:0]    hall_out;
  logic          step, dir, seq_err, period_valid, stalled;
  logic [CW-1:0] count;
  logic [EW-1:0] err_count;
  logic [PW-1:0] period;

  hall_input_conditioner #(
    .FILTER_CYCLES(F), .COUNT_WIDTH(CW), .PERIOD_WIDTH(PW), .ERR_WIDTH(EW)
  ) dut (
    .clk(clk), .rst(rst), .hall(hall), .hall_out(hall_out), .step(step), .dir(dir),
    .count(count), .seq_err(seq_err), .err_count(err_count), .period(period),
    .period_valid(period_valid), .stalled(stalled)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [2:0]    ho;
    logic          st;
    logic          dr;
    logic [CW-1:0] cnt;
    logic          se;
    logic [PW-1:0] per;
    logic          pv;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   mon_en = 1'b0;
  logic [2:0] last_ho;

  logic [2:0]    m_hall;
  int            m_pos;
  logic          m_dir;
  logic [CW-1:0] m_count;
  int            m_last_step;
  logic [PW-1:0] m_period;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int pos_of(input logic [2:0] c);
    case (c)
      3'b001: return 0;
      3'b011: return 1;
      3'b010: return 2;
      3'b110: return 3;
      3'b100: return 4;
      3'b101: return 5;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_hall      = 3'b111;
    m_pos       = -1;
    m_dir       = 1'b0;
    m_count     = '0;
    m_last_step = -1000000;
    m_period    = '1;
  endtask

  task automatic predict(input logic [2:0] code, input int acc);
    exp_t e;
    int   p, d;
    bit   fw;
    p = pos_of(code);
    e.cyc = acc; e.ho = code; e.st = 1'b0; e.se = 1'b0; e.pv = 1'b0;
    if (p < 0) begin
      e.se  = 1'b1;
      m_pos = -1;
    end else if (m_pos < 0) begin
      m_pos = p;
    end else if (p == (m_pos + 1) % 6 || p == (m_pos + 5) % 6) begin
      fw   = (p == (m_pos + 1) % 6);
      d    = acc - m_last_step;
      e.st = 1'b1;
      if (PM && (fw == m_dir) && (d < MAXP)) begin
        m_period = PW'(d);
        e.pv     = 1'b1;
      end else begin
        m_period = '1;
      end
      m_dir       = fw;
      m_count     = fw ? m_count + 1'b1 : m_count - 1'b1;
      m_last_step = acc;
      m_pos       = p;
    end else begin
      e.se  = 1'b1;
      m_pos = p;
    end
    e.dr = m_dir; e.cnt = m_count; e.per = m_period;
    sb.push_back(e);
    m_hall = code;
  endtask

  // Raw code is presented for n rising edges starting at the next one.
  task automatic hold(input logic [2:0] code, input int n);
    @(negedge clk);
    hall = code;
    if (n >= F && code != m_hall) predict(code, cyc + F + 3);
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hall_out"}, hall_out, 3'b111);
    check({tag, "_step"}, step, 0);
    check({tag, "_dir"}, dir, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_seq_err"}, seq_err, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_period"}, period, MAXP);
    check({tag, "_period_valid"}, period_valid, 0);
    check({tag, "_stalled"}, stalled, PM);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (hall_out !== last_ho) begin
        check("sb_pending", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("evt_cycle", cyc, mon_e.cyc);
          check("evt_hall_out", hall_out, mon_e.ho);
          check("evt_step", step, mon_e.st);
          check("evt_dir", dir, mon_e.dr);
          check("evt_count", count, mon_e.cnt);
          check("evt_seq_err", seq_err, mon_e.se);
          check("evt_period", period, mon_e.per);
          check("evt_period_valid", period_valid, mon_e.pv);
        end
      end else begin
        check("idle_pulses", {step, seq_err, period_valid}, 0);
      end
      last_ho = hall_out;
    end
  end

  initial begin
    hall = 3'b111;
    rst  = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rst0");
    last_ho = 3'b111;
    mon_en  = 1'b1;

    hold(3'b001, 40);
    check("init_count", count, 0);

    hold(3'b011, 100); hold(3'b010, 100); hold(3'b110, 100);
    hold(3'b100, 100); hold(3'b101, 100); hold(3'b001, 100);
    check("fwd_count", count, 6);
    check("fwd_dir", dir, 1);

    hold(3'b011, 100); hold(3'b001, 100);
    check("rev_count", count, 6);
    check("rev_dir", dir, 0);

    hold(3'b011, 5); hold(3'b001, 60);
    check("glitch_hall_out", hall_out, 3'b001);

    hold(3'b010, 100); hold(3'b000, 100);
    check("err_count_2", err_count, 2);
    check("illegal_passthru", hall_out, 3'b000);
    hold(3'b011, 100);
    check("resync_err_count", err_count, 2);
    hold(3'b010, 100);
    hold(3'b110, 1100);
    check("stalled_hold", stalled, PM);
    hold(3'b100, 100);
    check("after_stall_count", count, 9);
    check("sb_drained_1", sb.size(), 0);

    mon_en = 1'b0;
    @(negedge clk);
    hall = 3'b111;
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    last_ho = 3'b111;
    mon_en  = 1'b1;

    hold(3'b001, 40);
    hold(3'b011, 40);
    hold(3'b010, F - 1); hold(3'b011, 40);
    hold(3'b010, F);     hold(3'b011, 40);
    check("final_count", count, 1);
    repeat (5) @(negedge clk);
    check("sb_drained_2", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
